// File: rtl/fever_pkg.sv
// Shared definitions for the fever status peripheral: alarm states,
// default bus addresses and the event counter ceiling.
package fever_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        NORMAL = 2'd1,
        ALERT  = 2'd2,
        ACKED  = 2'd3
    } fever_state_e;

    localparam logic [31:0] DEF_THRESH_ADDR = 32'h0000_0000;
    localparam logic [31:0] DEF_MEAS_ADDR   = 32'h0000_0004;
    localparam logic [31:0] DEF_STATUS_ADDR = 32'h0000_000C;

    localparam logic [7:0] EVENT_MAX = 8'd255;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == EVENT_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/blink_timer.sv
// Half-period counter driving a toggling LED; restart forces the LED on
// and begins a fresh half-period.
module blink_timer #(
    parameter int unsigned BLINK_HALF = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    input  logic enable,
    output logic led
);

    localparam int unsigned CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(BLINK_HALF - 1);

    logic [CW-1:0] r_cnt;
    logic          r_led;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= '0;
            r_led <= 1'b0;
        end else if (restart) begin
            r_cnt <= '0;
            r_led <= 1'b1;
        end else if (enable) begin
            if (r_cnt == LAST) begin
                r_cnt <= '0;
                r_led <= ~r_led;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign led = r_led;

endmodule

// File: rtl/fever_status_unit.sv
// Store-snooping status peripheral: captures threshold/measurement/status
// words, cross-checks the written fever decision and runs the alarm FSM.
module fever_status_unit
    import fever_pkg::*;
#(
    parameter logic [31:0] THRESH_ADDR = DEF_THRESH_ADDR,
    parameter logic [31:0] MEAS_ADDR   = DEF_MEAS_ADDR,
    parameter logic [31:0] STATUS_ADDR = DEF_STATUS_ADDR,
    parameter int unsigned BLINK_HALF  = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        ack,
    output logic [31:0] thresh_q,
    output logic [31:0] meas_q,
    output logic        status_valid,
    output logic        fever,
    output logic        alarm_led,
    output logic        mismatch,
    output logic [7:0]  event_count
);

    logic         w_aligned, w_thr_st, w_meas_st, w_stat_st, w_stat_nz;
    logic         w_restart, w_count_inc, w_blink_en, w_blink_led;
    fever_state_e r_state, w_state_next;

    logic [31:0] r_thresh, r_meas;
    logic        r_have_thresh, r_have_meas;
    logic        r_status_valid, r_fever, r_mismatch;
    logic [7:0]  r_event_count;

    assign w_aligned = mem_we && (mem_addr[1:0] == 2'b00);
    assign w_thr_st  = w_aligned && (mem_addr == THRESH_ADDR);
    assign w_meas_st = w_aligned && (mem_addr == MEAS_ADDR);
    assign w_stat_st = w_aligned && (mem_addr == STATUS_ADDR);
    assign w_stat_nz = |mem_wdata;

    // A status store always takes priority over ack in the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_restart    = 1'b0;
        w_count_inc  = 1'b0;
        if (w_stat_st) begin
            if (w_stat_nz) begin
                w_state_next = ALERT;
                w_restart    = 1'b1;
                w_count_inc  = (r_state == IDLE) || (r_state == NORMAL);
            end else begin
                w_state_next = NORMAL;
            end
        end else if (ack && (r_state == ALERT)) begin
            w_state_next = ACKED;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= IDLE;
            r_thresh       <= '0;
            r_meas         <= '0;
            r_have_thresh  <= 1'b0;
            r_have_meas    <= 1'b0;
            r_status_valid <= 1'b0;
            r_fever        <= 1'b0;
            r_mismatch     <= 1'b0;
            r_event_count  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_thr_st) begin
                r_thresh      <= mem_wdata;
                r_have_thresh <= 1'b1;
            end
            if (w_meas_st) begin
                r_meas      <= mem_wdata;
                r_have_meas <= 1'b1;
            end
            if (w_stat_st) begin
                r_status_valid <= 1'b1;
                r_fever        <= w_stat_nz;
                r_mismatch     <= r_have_thresh && r_have_meas &&
                                  (w_stat_nz != (r_thresh < r_meas));
            end
            if (w_count_inc) begin
                r_event_count <= sat_inc(r_event_count);
            end
        end
    end

    assign w_blink_en = (r_state == ALERT);

    blink_timer #(
        .BLINK_HALF(BLINK_HALF)
    ) u_blink (
        .clock  (clock),
        .reset  (reset),
        .restart(w_restart),
        .enable (w_blink_en),
        .led    (w_blink_led)
    );

    always_comb begin
        alarm_led = 1'b0;
        unique case (r_state)
            IDLE:   alarm_led = 1'b0;
            NORMAL: alarm_led = 1'b0;
            ALERT:  alarm_led = w_blink_led;
            ACKED:  alarm_led = 1'b1;
        endcase
    end

    assign thresh_q     = r_thresh;
    assign meas_q       = r_meas;
    assign status_valid = r_status_valid;
    assign fever        = r_fever;
    assign mismatch     = r_mismatch;
    assign event_count  = r_event_count;

endmodule

// File: tb/tb_fever_status_unit.sv
// Bench for fever_status_unit: directed scenarios with literal expectations
// plus randomized traffic checked each cycle against a behavioural model.
module tb_fever_status_unit;

    localparam int BH = 4;
    localparam int M_IDLE = 0, M_NORMAL = 1, M_ALERT = 2, M_ACKED = 3;

    logic        clock = 1'b0;
    logic        reset, mem_we, ack;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] thresh_q, meas_q;
    logic        status_valid, fever, alarm_led, mismatch;
    logic [7:0]  event_count;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    fever_status_unit #(
        .THRESH_ADDR(32'h0000_0000),
        .MEAS_ADDR  (32'h0000_0004),
        .STATUS_ADDR(32'h0000_000C),
        .BLINK_HALF (BH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .ack         (ack),
        .thresh_q    (thresh_q),
        .meas_q      (meas_q),
        .status_valid(status_valid),
        .fever       (fever),
        .alarm_led   (alarm_led),
        .mismatch    (mismatch),
        .event_count (event_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode plus cycles spent in the current alert episode.
    logic [31:0] m_thresh = 0, m_meas = 0;
    bit m_have_t = 0, m_have_m = 0, m_valid = 0, m_fever = 0, m_mismatch = 0;
    int m_count = 0, m_mode = M_IDLE, m_age = 0;
    bit acc;

    always @(posedge clock) begin
        acc = mem_we && (mem_addr[1:0] == 2'b00);
        if (reset) begin
            m_thresh = 0; m_meas = 0; m_have_t = 0; m_have_m = 0;
            m_valid = 0; m_fever = 0; m_mismatch = 0;
            m_count = 0; m_mode = M_IDLE; m_age = 0;
        end else begin
            if (acc && mem_addr == 32'hC) begin
                m_mismatch = m_have_t && m_have_m &&
                             ((mem_wdata != 0) != (m_thresh < m_meas));
                m_valid = 1;
                m_fever = (mem_wdata != 0);
                if (mem_wdata != 0) begin
                    if ((m_mode == M_IDLE || m_mode == M_NORMAL) && m_count < 255) m_count++;
                    m_mode = M_ALERT;
                    m_age = 0;
                end else begin
                    m_mode = M_NORMAL;
                end
            end else if (m_mode == M_ALERT) begin
                if (ack) m_mode = M_ACKED;
                else m_age++;
            end
            if (acc && mem_addr == 32'h0) begin m_thresh = mem_wdata; m_have_t = 1; end
            if (acc && mem_addr == 32'h4) begin m_meas = mem_wdata; m_have_m = 1; end
        end
    end

    always @(negedge clock) begin
        if (chk_on) begin
            logic exp_led;
            exp_led = (m_mode == M_ACKED) ? 1'b1 :
                      (m_mode == M_ALERT) ? (((m_age / BH) % 2) == 0) : 1'b0;
            chk("thresh_q", thresh_q, m_thresh);
            chk("meas_q", meas_q, m_meas);
            chk("status_valid", {31'b0, status_valid}, {31'b0, m_valid});
            chk("fever", {31'b0, fever}, {31'b0, m_fever});
            chk("mismatch", {31'b0, mismatch}, {31'b0, m_mismatch});
            chk("event_count", {24'b0, event_count}, m_count);
            chk("alarm_led", {31'b0, alarm_led}, {31'b0, exp_led});
        end
    end

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        mem_we = 1'b1; mem_addr = a; mem_wdata = d;
        @(posedge clock); #1;
        mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    logic [8:0]  led_seq;
    logic [31:0] addr_tab [8];

    initial begin
        reset = 1'b1; mem_we = 0; ack = 0; mem_addr = 0; mem_wdata = 0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk_on = 1'b1;
        chk("rst_event_count", {24'b0, event_count}, 0);
        chk("rst_led", {31'b0, alarm_led}, 0);

        // Normal reading
        store(32'h0, 38); store(32'h4, 36); store(32'hC, 0);
        chk("t1_fever", {31'b0, fever}, 0);
        chk("t1_mismatch", {31'b0, mismatch}, 0);
        chk("t1_led", {31'b0, alarm_led}, 0);
        chk("t1_count", {24'b0, event_count}, 0);
        chk("t1_valid", {31'b0, status_valid}, 1);

        // Fever with blink pattern 1,1,1,1,0,0,0,0,1
        store(32'h0, 38); store(32'h4, 40); store(32'hC, 1);
        chk("t2_fever", {31'b0, fever}, 1);
        chk("t2_mismatch", {31'b0, mismatch}, 0);
        chk("t2_count", {24'b0, event_count}, 1);
        led_seq = 9'b100001111;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) idle(1);
            chk("t2_led_seq", {31'b0, alarm_led}, {31'b0, led_seq[i]});
        end

        // Disagreeing status, then status before any captures after reset
        store(32'hC, 0);
        chk("t3_mismatch", {31'b0, mismatch}, 1);
        chk("t3_led", {31'b0, alarm_led}, 0);
        do_reset();
        store(32'hC, 1);
        chk("t3_no_caps_mismatch", {31'b0, mismatch}, 0);
        chk("t3_count", {24'b0, event_count}, 1);
        store(32'hC, 0);
        chk("t3_no_caps_mismatch0", {31'b0, mismatch}, 0);

        // Acknowledge, then ack colliding with a fever store
        store(32'h0, 38); store(32'h4, 40); store(32'hC, 1);
        idle(5);
        chk("t4_led_blink_off", {31'b0, alarm_led}, 0);
        ack = 1'b1; @(posedge clock); #1; ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("t4_acked_led", {31'b0, alarm_led}, 1);
            idle(1);
        end
        ack = 1'b1; store(32'hC, 1); ack = 1'b0;
        chk("t4_reentry_led", {31'b0, alarm_led}, 1);
        chk("t4_count", {24'b0, event_count}, 2);
        idle(4);
        chk("t4_reentry_blink_off", {31'b0, alarm_led}, 0);

        // Ignored stores
        store(32'hD, 0);
        chk("t5_misaligned_fever", {31'b0, fever}, 1);
        mem_we = 1'b0; mem_addr = 32'hC; mem_wdata = 0;
        @(posedge clock); #1;
        mem_addr = 0;
        chk("t5_no_we_fever", {31'b0, fever}, 1);
        chk("t5_no_we_count", {24'b0, event_count}, 2);
        for (int i = 0; i < 600; i++) store(32'hC, (i % 2 == 0) ? 32'd0 : 32'd1);
        chk("t5_saturated", {24'b0, event_count}, 255);

        // Reset mid-alert with a concurrent store and ack
        store(32'hC, 1); idle(2);
        reset = 1'b1; ack = 1'b1; mem_we = 1'b1; mem_addr = 32'hC; mem_wdata = 1;
        @(posedge clock); #1;
        reset = 1'b0; ack = 1'b0; mem_we = 1'b0; mem_addr = 0; mem_wdata = 0;
        chk("t6_thresh", thresh_q, 0);
        chk("t6_meas", meas_q, 0);
        chk("t6_valid", {31'b0, status_valid}, 0);
        chk("t6_fever", {31'b0, fever}, 0);
        chk("t6_led", {31'b0, alarm_led}, 0);
        chk("t6_mismatch", {31'b0, mismatch}, 0);
        chk("t6_count", {24'b0, event_count}, 0);
        store(32'hC, 1);
        chk("t6_from_idle_count", {24'b0, event_count}, 1);

        // Randomized traffic
        addr_tab[0] = 32'h0; addr_tab[1] = 32'h4; addr_tab[2] = 32'hC; addr_tab[3] = 32'hC;
        addr_tab[4] = 32'hD; addr_tab[5] = 32'h8; addr_tab[6] = 32'h1; addr_tab[7] = 32'h10C;
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 199) == 0);
            mem_we    = $urandom_range(0, 1);
            mem_addr  = addr_tab[$urandom_range(0, 7)];
            mem_wdata = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(30, 45));
            ack       = ($urandom_range(0, 3) == 0);
            @(posedge clock); #1;
        end
        reset = 0; mem_we = 0; ack = 0;
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
